// File: rtl/updn_counter_monitor.sv
// ----------------------------------------------------------------------------
// updn_counter_monitor
//
// Run-time reference-model checker for a loadable up/down counter. On every
// clock edge it samples the counter controls and the counter output. From
// these it predicts what the counter must show on the next edge, and it
// compares the current output against the prediction formed one edge
// earlier. Each mismatch is reported with a class code and counted. The
// first mismatch after reset or clear is captured.
//
// The prediction is always formed from the observed data_out, never from the
// previous prediction. A single corrupted value therefore raises exactly one
// error instead of a cascade.
//
// Parameters
//   WIDTH      counter data width
//   SATURATE   0: counter wraps modulo 2^WIDTH, 1: counter clamps at ends
//   ERR_CNT_W  width of the saturating error counter
//
// Ports
//   clk            in   monitor clock (same clock as the counter)
//   rst_           in   asynchronous active-low reset
//   ld_cnt_        in   observed counter load, active low
//   updn_cnt       in   observed direction, 1 = up, 0 = down
//   count_enb      in   observed counter enable
//   data_in        in   observed counter load value
//   data_out       in   observed counter output
//   chk_en         in   enables checking
//   err_clr        in   synchronous clear of err_cnt and first-error capture
//   err            out  one-cycle mismatch pulse
//   err_code       out  mismatch class: 00 load/reset, 01 hold, 10 up, 11 down
//   err_cnt        out  saturating mismatch count
//   first_err_vld  out  sticky, first-error capture registers are valid
//   first_err_exp  out  expected value at the first error
//   first_err_act  out  observed value at the first error
//   dbg_state      out  monitor state: 00 IDLE, 01 ARM, 10 CHECK
//
// Handshake: there is no valid/ready flow control. err is a single-cycle
// qualifier for err_code. An edge with err high has exactly one mismatch
// behind it. err_code is only meaningful while err is high and reads 00
// otherwise.
// ----------------------------------------------------------------------------
module updn_counter_monitor #(
    parameter int WIDTH     = 8,
    parameter int SATURATE  = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 ld_cnt_,
    input  logic                 updn_cnt,
    input  logic                 count_enb,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     data_out,
    input  logic                 chk_en,
    input  logic                 err_clr,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 first_err_vld,
    output logic [WIDTH-1:0]     first_err_exp,
    output logic [WIDTH-1:0]     first_err_act,
    output logic [1:0]           dbg_state
);

    // Operation classes, also used directly as err_code.
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_HOLD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    // Monitor states. A prediction is valid in every state except IDLE.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARM   = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;

    localparam logic [WIDTH-1:0]     DATA_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]     DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     DATA_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Prediction state
    logic [WIDTH-1:0]     r_exp;
    logic [1:0]           r_op_q;
    logic [1:0]           r_state;

    // Report state
    logic                 r_err;
    logic [1:0]           r_err_code;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_first_err_vld;
    logic [WIDTH-1:0]     r_first_err_exp;
    logic [WIDTH-1:0]     r_first_err_act;

    // Combinational next values
    logic [WIDTH-1:0]     w_up_val;
    logic [WIDTH-1:0]     w_down_val;
    logic [WIDTH-1:0]     w_exp_next;
    logic [1:0]           w_op_next;
    logic [1:0]           w_state_next;
    logic                 w_pred_vld;
    logic                 w_mismatch;
    logic                 w_cap_open;
    logic [ERR_CNT_W-1:0] w_cnt_base;
    logic [ERR_CNT_W-1:0] w_cnt_next;

    // ------------------------------------------------------------------
    // Next-count arithmetic, WIDTH bits. In saturate mode the counter
    // sticks at the end it is driving into. In wrap mode plain modular
    // add/subtract is exactly right.
    // ------------------------------------------------------------------
    always_comb begin
        w_up_val   = data_out + DATA_ONE;
        w_down_val = data_out - DATA_ONE;
        if (SATURATE != 0) begin
            if (data_out == DATA_ONES) begin
                w_up_val = DATA_ONES;
            end
            if (data_out == DATA_ZERO) begin
                w_down_val = DATA_ZERO;
            end
        end
    end

    // Reference operation in priority order: load, up, down, hold.
    always_comb begin
        w_exp_next = data_out;
        w_op_next  = OP_HOLD;
        if (!ld_cnt_) begin
            w_exp_next = data_in;
            w_op_next  = OP_LOAD;
        end else if (count_enb && updn_cnt) begin
            w_exp_next = w_up_val;
            w_op_next  = OP_UP;
        end else if (count_enb) begin
            w_exp_next = w_down_val;
            w_op_next  = OP_DOWN;
        end
    end

    // ------------------------------------------------------------------
    // Monitor FSM. Dropping chk_en returns to IDLE from anywhere. The first
    // edge with chk_en high only forms a prediction (ARM). Compares start
    // on the following edge (CHECK).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = ST_CHECK;
        if (!chk_en) begin
            w_state_next = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            w_state_next = ST_ARM;
        end
    end

    assign w_pred_vld = (r_state != ST_IDLE);

    // chk_en is used live. An edge that samples chk_en low therefore never
    // reports, even when a prediction is still pending.
    assign w_mismatch = w_pred_vld && chk_en && (data_out != r_exp);

    // ------------------------------------------------------------------
    // Error bookkeeping. The clear is applied first and then the error of
    // the same edge, so a coincident clear and mismatch leaves a count of
    // one and a fresh capture.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_base = err_clr ? {ERR_CNT_W{1'b0}} : r_err_cnt;
        w_cnt_next = w_cnt_base;
        if (w_mismatch && (w_cnt_base != CNT_MAX)) begin
            w_cnt_next = w_cnt_base + CNT_ONE;
        end
    end

    assign w_cap_open = err_clr || !r_first_err_vld;

    // ------------------------------------------------------------------
    // Registers. Reset leaves a valid prediction of zero, so the counter's
    // own reset value is checked on the first edge after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_exp           <= DATA_ZERO;
            r_op_q          <= OP_LOAD;
            r_state         <= ST_CHECK;
            r_err           <= 1'b0;
            r_err_code      <= OP_LOAD;
            r_err_cnt       <= {ERR_CNT_W{1'b0}};
            r_first_err_vld <= 1'b0;
            r_first_err_exp <= DATA_ZERO;
            r_first_err_act <= DATA_ZERO;
        end else begin
            r_exp      <= w_exp_next;
            r_op_q     <= w_op_next;
            r_state    <= w_state_next;
            r_err      <= w_mismatch;
            r_err_code <= w_mismatch ? r_op_q : OP_LOAD;
            r_err_cnt  <= w_cnt_next;
            if (w_mismatch && w_cap_open) begin
                r_first_err_vld <= 1'b1;
                r_first_err_exp <= r_exp;
                r_first_err_act <= data_out;
            end else if (err_clr) begin
                r_first_err_vld <= 1'b0;
                r_first_err_exp <= DATA_ZERO;
                r_first_err_act <= DATA_ZERO;
            end
        end
    end

    assign err           = r_err;
    assign err_code      = r_err_code;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_first_err_vld;
    assign first_err_exp = r_first_err_exp;
    assign first_err_act = r_first_err_act;
    assign dbg_state     = r_state;

endmodule
